// File: rtl/uart_loader.sv
// UART host-link loader: 8N1 receiver plus frame parser that turns
// A5/addr/len/payload frames into 32-bit word writes on a valid/ready port.
module uart_loader #(
  parameter int unsigned CLK_HZ     = 100800000,
  parameter int unsigned SCLK_HZ    = 115200,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uart_rxd,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_d,
  output logic                  busy,
  output logic                  done,
  output logic                  err_frame,
  output logic                  err_overrun,
  input  logic                  err_clear
);

  localparam int unsigned DIV = CLK_HZ / SCLK_HZ;
  localparam int unsigned CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
  localparam logic [7:0]    SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {P_SYNC, P_ADDR0, P_ADDR1, P_LEN, P_DATA, P_LAST} p_state_e;

  logic                  rxd_meta_q, rxd_sync_q;
  rx_state_e             rx_state_q, rx_state_d;
  logic                  armed_q, armed_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shift_q, shift_d;
  logic                  byte_valid_q, byte_valid_d;
  logic                  ferr_q, ferr_d;

  p_state_e              p_state_q, p_state_d;
  logic [7:0]            addr_lo_q, addr_lo_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]            words_q, words_d;
  logic [1:0]            idx_q, idx_d;
  logic [23:0]           word_q, word_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_d_q, mem_d_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_frame_q, err_frame_d;
  logic                  err_overrun_q, err_overrun_d;

  logic                  accept_c;
  logic [31:0]           full_word_c;

  // Bit receiver: start-edge detect, mid-bit sampling, stop check
  always_comb begin
    rx_state_d   = rx_state_q;
    armed_d      = armed_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    ferr_d       = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        armed_d = rxd_sync_q;
        if (armed_q && !rxd_sync_q) begin
          rx_state_d = RX_START;
          cnt_d      = CNT_HALF;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          armed_d = 1'b0;
          if (!rxd_sync_q) begin
            rx_state_d = RX_DATA;
            bit_cnt_d  = 3'd0;
            cnt_d      = CNT_FULL;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rxd_sync_q, shift_q[7:1]};
          cnt_d   = CNT_FULL;
          if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
          else                   bit_cnt_d  = bit_cnt_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          byte_valid_d = rxd_sync_q;
          ferr_d       = !rxd_sync_q;
          rx_state_d   = RX_IDLE;
          // Re-arm only after the line has been seen high again
          armed_d      = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign accept_c    = mem_valid_q & mem_ready;
  assign full_word_c = {shift_q, word_q};

  // Frame parser and memory write port
  always_comb begin
    p_state_d     = p_state_q;
    addr_lo_d     = addr_lo_q;
    waddr_d       = waddr_q;
    words_d       = words_q;
    idx_d         = idx_q;
    word_d        = word_q;
    mem_valid_d   = mem_valid_q;
    mem_addr_d    = mem_addr_q;
    mem_d_d       = mem_d_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_frame_d   = (err_frame_q & ~err_clear) | ferr_q;
    err_overrun_d = err_overrun_q & ~err_clear;

    if (accept_c) begin
      mem_valid_d = 1'b0;
      if (p_state_q == P_LAST) begin
        done_d    = 1'b1;
        busy_d    = 1'b0;
        p_state_d = P_SYNC;
      end
    end

    if (ferr_q) begin
      p_state_d = P_SYNC;
      busy_d    = 1'b0;
    end else if (byte_valid_q) begin
      case (p_state_q)
        P_SYNC: begin
          if (shift_q == SYNC_BYTE) begin
            p_state_d = P_ADDR0;
            busy_d    = 1'b1;
          end
        end
        P_ADDR0: begin
          addr_lo_d = shift_q;
          p_state_d = P_ADDR1;
        end
        P_ADDR1: begin
          waddr_d   = ADDR_WIDTH'({shift_q, addr_lo_q});
          p_state_d = P_LEN;
        end
        P_LEN: begin
          words_d   = shift_q;
          idx_d     = 2'd0;
          p_state_d = P_DATA;
        end
        P_DATA: begin
          if (idx_q != 2'd3) begin
            word_d = {shift_q, word_q[23:8]};
            idx_d  = idx_q + 2'd1;
          end else begin
            idx_d   = 2'd0;
            waddr_d = waddr_q + ADDR_WIDTH'(1);
            words_d = words_q - 8'd1;
            // A write being accepted this cycle frees the port for the new word
            if (!mem_valid_q || mem_ready) begin
              mem_valid_d = 1'b1;
              mem_addr_d  = waddr_q;
              mem_d_d     = full_word_c;
              if (words_q == 8'd0) p_state_d = P_LAST;
            end else begin
              err_overrun_d = 1'b1;
              if (words_q == 8'd0) begin
                done_d    = 1'b1;
                busy_d    = 1'b0;
                p_state_d = P_SYNC;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      rxd_meta_q    <= 1'b1;
      rxd_sync_q    <= 1'b1;
      rx_state_q    <= RX_IDLE;
      armed_q       <= 1'b0;
      cnt_q         <= '0;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'd0;
      byte_valid_q  <= 1'b0;
      ferr_q        <= 1'b0;
      p_state_q     <= P_SYNC;
      addr_lo_q     <= 8'd0;
      waddr_q       <= '0;
      words_q       <= 8'd0;
      idx_q         <= 2'd0;
      word_q        <= 24'd0;
      mem_valid_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_d_q       <= 32'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      rxd_meta_q    <= uart_rxd;
      rxd_sync_q    <= rxd_meta_q;
      rx_state_q    <= rx_state_d;
      armed_q       <= armed_d;
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      byte_valid_q  <= byte_valid_d;
      ferr_q        <= ferr_d;
      p_state_q     <= p_state_d;
      addr_lo_q     <= addr_lo_d;
      waddr_q       <= waddr_d;
      words_q       <= words_d;
      idx_q         <= idx_d;
      word_q        <= word_d;
      mem_valid_q   <= mem_valid_d;
      mem_addr_q    <= mem_addr_d;
      mem_d_q       <= mem_d_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_frame_q   <= err_frame_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign mem_valid   = mem_valid_q;
  assign mem_addr    = mem_addr_q;
  assign mem_d       = mem_d_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_frame   = err_frame_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- UART receive end of the host link; the host side transmits.
- Deserialises 8N1 bytes from uart_rxd, parses host load frames and issues 32-bit word writes on a valid/ready memory port.
- Sits between the board pin and the SoC program/data memory master.
- Used to download PE programs and data at runtime.

Parameters:
- CLK_HZ, 100800000: clk frequency in Hz.
- SCLK_HZ, 115200: baud rate. DIV = CLK_HZ/SCLK_HZ, integer-truncated; DIV must be >= 4.
- ADDR_WIDTH, 16: word address width. Only the low ADDR_WIDTH bits of the 16-bit frame address are used.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset. Low = reset.
- uart_rxd  in  1  serial input; asynchronous; idles high.
- mem_valid  out  1  write request.
- mem_ready  in  1  write accept.
- mem_addr  out  ADDR_WIDTH  word address.
- mem_d  out  32  write data.
- busy  out  1  high from sync byte accepted until frame end or abort.
- done  out  1  one-cycle pulse when the last word of a frame is accepted.
- err_frame  out  1  sticky; stop bit sampled low.
- err_overrun  out  1  sticky; word completed while mem_valid was still pending.
- err_clear  in  1  clears both sticky errors; reset and err_clear each clear them.

Behaviour:
- Reset (reset=0 at a clk edge): all outputs 0; mem_addr and mem_d 0; both FSMs idle; partial byte, word and frame discarded. Reset mid-frame aborts the frame silently: no write, no done.
- Input path: uart_rxd passes through a 2-flop synchroniser (preset to 1) before any use.
- Bit receiver states:
  - RX_IDLE: a synchronised 1->0 transition loads the counter with DIV/2-1 and moves to RX_START.
  - RX_START: at count 0, if the line is still 0, go to RX_DATA with bit counter 0 and counter DIV-1. Otherwise it is a false start; return to RX_IDLE.
  - RX_DATA: sample at each count 0, LSB first; 8 bits, reloading the counter to DIV-1 between bits.
  - RX_STOP: sample after DIV cycles. If 1, pulse byte_valid for 1 cycle. If 0, set err_frame, no byte_valid, and abort the frame parser to P_SYNC.
  - After the stop sample, return to RX_IDLE and wait for the line to be high before re-arming the edge detect.
- Frame format (bytes): 0xA5 sync, ADDR_LO, ADDR_HI, LEN, then (LEN+1) words of 4 bytes each, little-endian. Words per frame: 1..256.
- Parser states:
  - P_SYNC: bytes other than 0xA5 are ignored. 0xA5 moves to P_ADDR0 and sets busy=1.
  - P_ADDR0 -> P_ADDR1 -> P_LEN: capture address and length.
  - P_DATA: assemble the word, byte index 0..3.
  - After the 4th byte of a word:
    - If mem_valid=0: the next cycle sets mem_valid=1 with mem_addr = current address and mem_d = assembled word.
    - If mem_valid=1 (still pending): drop the new word, set err_overrun. Address and word count still advance.
- Memory handshake:
  - A transfer occurs on a clk edge with mem_valid & mem_ready.
  - mem_valid drops the following cycle unless a new word is ready in that same cycle.
  - mem_addr and mem_d are held stable while mem_valid=1 and mem_ready=0.
- Address: increments by 1 per word and wraps modulo 2^ADDR_WIDTH (0xFFFF -> 0x0000 at width 16).
- Frame end:
  - After the last word's accept, pulse done=1 for 1 cycle, drive busy=0, and return to P_SYNC.
  - If the last word was dropped by overrun, done pulses on the cycle its 4th byte completes.
- Simultaneous events: err_clear in the same cycle as an error set leaves the error set.
- Latency: mem_valid rises 1 clk after the byte_valid of a word's 4th byte. byte_valid fires about DIV*9.5 cycles after the start edge.

Test Plan (CLK_HZ=16, SCLK_HZ=1, so DIV=16):
1. Send A5 10 00 00 78 56 34 12, mem_ready=1 -> exactly one write, mem_addr=0x0010, mem_d=0x12345678; done pulses 1 cycle; busy 1->0.
2. Send A5 FF FF 01, words 0x00000001 and 0x00000002; mem_ready low 5 cycles on the first write -> mem_valid and data held stable across the stall; writes go to 0xFFFF then 0x0000.
3. Stop bit forced 0 on the ADDR_HI byte -> err_frame=1, no write, busy=0. A following valid frame writes correctly. err_clear -> err_frame=0.
4. uart_rxd low for 4 cycles (< DIV/2), then high -> no byte_valid, parser unchanged. Byte 0x5A while in P_SYNC -> ignored, busy stays 0.
5. LEN=01, mem_ready=0 held through both words -> first word pending; second word dropped; err_overrun=1; done pulses once.
6. reset=0 for 1 cycle after the 2nd payload byte -> all outputs 0, no write. A fresh full frame afterwards succeeds.
